// File: rtl/msp430x_regfile.sv
// MSP430/MSP430X CPU register file: R0..R15 with constant generator,
// size-aware post-increment, PC/SP sequencing and interrupt entry.
module msp430x_regfile #(
    parameter int              DW       = 20,
    parameter logic [DW-1:0]   RESET_PC = DW'('h04400),
    parameter logic [DW-1:0]   RESET_SP = DW'('h02400)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    srcA,
    input  logic [3:0]    dstA,
    input  logic [1:0]    srcAs,
    input  logic [1:0]    size,
    input  logic          RW,
    input  logic [DW-1:0] result,
    input  logic          srcInc,
    input  logic          dstInc,
    input  logic          pcInc,
    input  logic          pcLoad,
    input  logic [DW-1:0] pcNew,
    input  logic          srWE,
    input  logic [3:0]    SRnew,
    input  logic          intAck,
    input  logic [DW-1:0] isrVec,
    output logic [DW-1:0] Rsrc,
    output logic [DW-1:0] Rdst,
    output logic [DW-1:0] PCout,
    output logic [DW-1:0] SPout,
    output logic [8:0]    SRcurrent,
    output logic          GIE,
    output logic          busy,
    output logic [DW-1:0] pushData
);

    typedef enum logic [1:0] {
        IDLE,
        PUSH_PC,
        PUSH_SR,
        VECTOR
    } state_t;

    localparam logic [DW-1:0] ONE    = DW'(1);
    localparam logic [DW-1:0] TWO    = DW'(2);
    localparam logic [DW-1:0] FOUR   = DW'(4);
    localparam logic [DW-1:0] EIGHT  = DW'(8);
    localparam logic [DW-1:0] EVEN   = ~DW'(1);
    localparam logic [DW-1:0] SRMASK = DW'(9'h1ff);
    localparam logic [DW-1:0] SCG0   = DW'(9'h040);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] rf     [16];
    logic [DW-1:0] rf_nxt [16];
    logic [DW-1:0] wdata;
    logic [DW-1:0] inc_gp;
    logic [DW-1:0] inc_sp;
    logic [DW-1:0] sr_flags;
    logic [DW-1:0] sr_word;
    logic [15:0]   inc_hit;

    always_comb begin
        unique case (size)
            2'b01:   wdata = DW'(result[7:0]);
            2'b10:   wdata = result;
            default: wdata = DW'(result[15:0]);
        endcase
        inc_sp  = (size == 2'b10 && DW > 16) ? FOUR : TWO;
        inc_gp  = (size == 2'b01) ? ONE : inc_sp;
        inc_hit = '0;
        if (srcInc) inc_hit[srcA] = 1'b1;
        if (dstInc) inc_hit[dstA] = 1'b1;
        sr_flags      = rf[2];
        sr_flags[8]   = SRnew[3];
        sr_flags[2:0] = SRnew[2:0];
        // Extended PC bits ride in SR[15:12] of the pushed status word
        sr_word = ((rf[0] >> 16) << 12) | (rf[2] & SRMASK);
    end

    always_comb begin
        rf_nxt    = rf;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (intAck) state_nxt = PUSH_PC;
                for (int i = 4; i < 16; i++) begin
                    if (RW && dstA == 4'(i))
                        rf_nxt[i] = wdata;
                    else if (inc_hit[i])
                        rf_nxt[i] = rf[i] + inc_gp;
                end
                if (RW && dstA == 4'd2)
                    rf_nxt[2] = wdata & SRMASK;
                else if (srWE)
                    rf_nxt[2] = sr_flags;
                else if (inc_hit[2])
                    rf_nxt[2] = (rf[2] + inc_gp) & SRMASK;
                if (RW && dstA == 4'd1)
                    rf_nxt[1] = wdata & EVEN;
                else if (inc_hit[1])
                    rf_nxt[1] = (rf[1] + inc_sp) & EVEN;
                if (pcLoad)
                    rf_nxt[0] = pcNew & EVEN;
                else if (RW && dstA == 4'd0)
                    rf_nxt[0] = wdata & EVEN;
                else if (pcInc || inc_hit[0])
                    rf_nxt[0] = rf[0] + TWO;
            end
            PUSH_PC: begin
                rf_nxt[1] = rf[1] - TWO;
                state_nxt = PUSH_SR;
            end
            PUSH_SR: begin
                rf_nxt[1] = rf[1] - TWO;
                state_nxt = VECTOR;
            end
            VECTOR: begin
                rf_nxt[0] = isrVec & EVEN;
                rf_nxt[2] = rf[2] & SCG0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            rf[0] <= RESET_PC;
            rf[1] <= RESET_SP;
            state <= IDLE;
        end else begin
            rf    <= rf_nxt;
            state <= state_nxt;
        end
    end

    always_comb begin
        Rsrc = rf[srcA];
        unique case (1'b1)
            srcA == 4'd3: begin
                unique case (srcAs)
                    2'b00: Rsrc = '0;
                    2'b01: Rsrc = ONE;
                    2'b10: Rsrc = TWO;
                    2'b11: Rsrc = '1;
                endcase
            end
            srcA == 4'd2 && srcAs == 2'b01: Rsrc = '0;
            srcA == 4'd2 && srcAs == 2'b10: Rsrc = FOUR;
            srcA == 4'd2 && srcAs == 2'b11: Rsrc = EIGHT;
            default: ;
        endcase
    end

    always_comb begin
        unique case (state)
            PUSH_PC: pushData = rf[0];
            PUSH_SR: pushData = sr_word;
            default: pushData = '0;
        endcase
    end

    assign Rdst      = rf[dstA];
    assign PCout     = rf[0];
    assign SPout     = rf[1];
    assign SRcurrent = rf[2][8:0];
    assign GIE       = rf[2][3];
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_msp430x_regfile.sv
// Bench for msp430x_regfile: directed plan steps then random traffic
// checked against a behavioural register-file model.
module tb_msp430x_regfile;

    localparam int DW = 20;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic [3:0]    srcA   = '0;
    logic [3:0]    dstA   = '0;
    logic [1:0]    srcAs  = '0;
    logic [1:0]    size   = '0;
    logic          RW     = 1'b0;
    logic [DW-1:0] result = '0;
    logic          srcInc = 1'b0;
    logic          dstInc = 1'b0;
    logic          pcInc  = 1'b0;
    logic          pcLoad = 1'b0;
    logic [DW-1:0] pcNew  = '0;
    logic          srWE   = 1'b0;
    logic [3:0]    SRnew  = '0;
    logic          intAck = 1'b0;
    logic [DW-1:0] isrVec = '0;
    logic [DW-1:0] Rsrc;
    logic [DW-1:0] Rdst;
    logic [DW-1:0] PCout;
    logic [DW-1:0] SPout;
    logic [8:0]    SRcurrent;
    logic          GIE;
    logic          busy;
    logic [DW-1:0] pushData;

    int checks = 0;
    int errors = 0;

    logic [19:0] m [16];
    int          phase = 0;

    msp430x_regfile #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .srcA(srcA), .dstA(dstA),
        .srcAs(srcAs), .size(size), .RW(RW), .result(result),
        .srcInc(srcInc), .dstInc(dstInc), .pcInc(pcInc),
        .pcLoad(pcLoad), .pcNew(pcNew), .srWE(srWE), .SRnew(SRnew),
        .intAck(intAck), .isrVec(isrVec), .Rsrc(Rsrc), .Rdst(Rdst),
        .PCout(PCout), .SPout(SPout), .SRcurrent(SRcurrent),
        .GIE(GIE), .busy(busy), .pushData(pushData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] obs,
                       input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] exp_src();
        logic [19:0] cg3 [4];
        logic [19:0] cg2 [4];
        cg3 = '{20'h0, 20'h1, 20'h2, 20'hfffff};
        cg2 = '{20'h0, 20'h0, 20'h4, 20'h8};
        if (srcA == 4'd3) return cg3[srcAs];
        if (srcA == 4'd2 && srcAs != 2'b00) return cg2[srcAs];
        return m[srcA];
    endfunction

    function automatic logic [19:0] exp_push();
        if (phase == 1) return m[0];
        if (phase == 2) return {4'h0, m[0][19:16], 3'b000, m[2][8:0]};
        return 20'h0;
    endfunction

    // One clock of architectural behaviour, evaluated on pre-edge inputs
    task automatic model_step();
        logic [19:0] n [16];
        logic [15:0] hit;
        logic [19:0] w;
        logic [19:0] amt;
        n = m;
        if (rst) begin
            foreach (n[i]) n[i] = 20'h0;
            n[0]  = 20'h04400;
            n[1]  = 20'h02400;
            phase = 0;
        end else if (phase == 1 || phase == 2) begin
            n[1] = m[1] - 20'd2;
            phase++;
        end else if (phase == 3) begin
            n[0]  = isrVec & ~20'h1;
            n[2]  = m[2] & 20'h040;
            phase = 0;
        end else begin
            hit = '0;
            if (srcInc) hit[srcA] = 1'b1;
            if (dstInc) hit[dstA] = 1'b1;
            case (size)
                2'd1:    w = {12'h0, result[7:0]};
                2'd2:    w = result;
                default: w = {4'h0, result[15:0]};
            endcase
            for (int r = 1; r < 16; r++) begin
                if (hit[r] && r != 3) begin
                    if (size == 2'd1) amt = (r == 1) ? 20'd2 : 20'd1;
                    else if (size == 2'd2) amt = 20'd4;
                    else amt = 20'd2;
                    n[r] = m[r] + amt;
                end
            end
            n[2] = n[2] & 20'h1ff;
            if (srWE) n[2] = {m[2][19:9], SRnew[3], m[2][7:3], SRnew[2:0]};
            if (RW && dstA != 4'd3 && dstA != 4'd0) n[dstA] = w;
            n[1] = n[1] & ~20'h1;
            n[2] = n[2] & 20'h1ff;
            if (pcLoad) n[0] = pcNew & ~20'h1;
            else if (RW && dstA == 4'd0) n[0] = w & ~20'h1;
            else if (pcInc || hit[0]) n[0] = m[0] + 20'd2;
            if (intAck) phase = 1;
        end
        m = n;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, PCout, m[0]);
        chk({tag, ".sp"}, SPout, m[1]);
        chk({tag, ".sr"}, {11'h0, SRcurrent}, m[2]);
        chk({tag, ".gie"}, {19'h0, GIE}, {19'h0, m[2][3]});
        chk({tag, ".busy"}, {19'h0, busy}, {19'h0, phase != 0});
        chk({tag, ".push"}, pushData, exp_push());
        chk({tag, ".rsrc"}, Rsrc, exp_src());
        chk({tag, ".rdst"}, Rdst, m[dstA]);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear();
        RW = 0; srcInc = 0; dstInc = 0; pcInc = 0; pcLoad = 0;
        srWE = 0; intAck = 0; size = 2'd0; srcAs = 2'd0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [19:0] v,
                      input logic [1:0] sz);
        clear();
        RW = 1; dstA = r; result = v; size = sz;
        tick("wr");
        RW = 0;
    endtask

    initial begin
        logic [19:0] cgv [4];
        cgv = '{20'h0, 20'h1, 20'h2, 20'hfffff};

        // Reset held three cycles
        rst = 1;
        repeat (3) tick("rst");
        rst = 0;
        chk("rst_pc", PCout, 20'h04400);
        chk("rst_sp", SPout, 20'h02400);
        chk("rst_busy", {19'h0, busy}, 20'h0);
        chk("rst_gie", {19'h0, GIE}, 20'h0);
        srcA = 4'd4; #1;
        chk("rst_r4", Rsrc, 20'h0);

        // Constant generator
        srcA = 4'd3;
        for (int a = 0; a < 4; a++) begin
            srcAs = 2'(a); #1;
            chk("cg_r3", Rsrc, cgv[a]);
        end
        srcA = 4'd2;
        srcAs = 2'd2; #1; chk("cg_r2_4", Rsrc, 20'h4);
        srcAs = 2'd3; #1; chk("cg_r2_8", Rsrc, 20'h8);
        srcAs = 2'd0;

        // Write widths
        wr(4'd5, 20'h789ab, 2'd1); chk("wr_byte", Rdst, 20'h000ab);
        wr(4'd5, 20'h789ab, 2'd0); chk("wr_word", Rdst, 20'h089ab);
        wr(4'd5, 20'h789ab, 2'd2); chk("wr_aw", Rdst, 20'h789ab);
        wr(4'd3, 20'h12345, 2'd2);
        chk("r3_raw", Rdst, 20'h0);
        srcA = 4'd3; srcAs = 2'd1; #1;
        chk("r3_cg", Rsrc, 20'h1);
        srcAs = 2'd0;
        wr(4'd2, 20'h001ff, 2'd0);
        chk("sr_wr", {11'h0, SRcurrent}, 20'h1ff);
        chk("sr_gie", {19'h0, GIE}, 20'h1);

        // Increments
        wr(4'd4, 20'h0fffe, 2'd0);
        srcA = 4'd4; srcInc = 1;
        size = 2'd0; tick("inc_w");  chk("inc_word", Rsrc, 20'h10000);
        size = 2'd1; tick("inc_b");  chk("inc_byte", Rsrc, 20'h10001);
        size = 2'd2; tick("inc_aw"); chk("inc_aw", Rsrc, 20'h10005);
        wr(4'd4, 20'hffffc, 2'd2);
        srcA = 4'd4; srcInc = 1; size = 2'd2;
        tick("wrap"); chk("inc_wrap", Rsrc, 20'h0);
        clear();
        srcA = 4'd1; srcInc = 1; size = 2'd1;
        tick("spinc"); chk("sp_byte", SPout, 20'h02402);
        wr(4'd6, 20'h00100, 2'd0);
        srcA = 4'd6; dstA = 4'd6; srcInc = 1; dstInc = 1;
        tick("dual"); chk("dual_inc", Rdst, 20'h00102);
        clear();

        // Priorities
        pcLoad = 1; pcNew = 20'h05000; RW = 1; dstA = 4'd0;
        result = 20'h01234; pcInc = 1;
        tick("pcpri"); chk("pc_pri", PCout, 20'h05000);
        clear();
        RW = 1; dstA = 4'd2; result = 20'h0; srWE = 1; SRnew = 4'hf;
        tick("srpri"); chk("sr_pri", {11'h0, SRcurrent}, 20'h0);
        clear();

        // Interrupt entry
        wr(4'd0, 20'h04410, 2'd0);
        wr(4'd1, 20'h02400, 2'd0);
        wr(4'd2, 20'h00048, 2'd0);
        isrVec = 20'h04457; intAck = 1;
        tick("ack");
        chk("pp_busy", {19'h0, busy}, 20'h1);
        chk("pp_push", pushData, 20'h04410);
        RW = 1; dstA = 4'd5; result = 20'h55555; size = 2'd2; pcInc = 1;
        tick("pp");
        chk("ps_push", pushData, 20'h00048);
        chk("ps_sp", SPout, 20'h023fe);
        tick("ps");
        chk("vec_busy", {19'h0, busy}, 20'h1);
        chk("vec_sp", SPout, 20'h023fc);
        chk("vec_push", pushData, 20'h0);
        clear();
        tick("vec");
        chk("isr_pc", PCout, 20'h04456);
        chk("isr_sr", {11'h0, SRcurrent}, 20'h040);
        chk("isr_gie", {19'h0, GIE}, 20'h0);
        chk("isr_busy", {19'h0, busy}, 20'h0);
        chk("isr_r5", Rdst, 20'h789ab);
        tick("post");

        // Reset during entry
        intAck = 1; tick("ack2");
        clear(); tick("pp2");
        chk("ps2_busy", {19'h0, busy}, 20'h1);
        rst = 1; tick("abort"); rst = 0;
        chk("ab_busy", {19'h0, busy}, 20'h0);
        chk("ab_sp", SPout, 20'h02400);
        chk("ab_pc", PCout, 20'h04400);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            srcA   = 4'($urandom_range(0, 15));
            dstA   = 4'($urandom_range(0, 15));
            srcAs  = 2'($urandom);
            size   = 2'($urandom);
            RW     = ($urandom_range(0, 2) == 0);
            result = 20'($urandom);
            srcInc = ($urandom_range(0, 3) == 0);
            dstInc = ($urandom_range(0, 3) == 0);
            pcInc  = ($urandom_range(0, 3) == 0);
            pcLoad = ($urandom_range(0, 7) == 0);
            pcNew  = 20'($urandom);
            srWE   = ($urandom_range(0, 3) == 0);
            SRnew  = 4'($urandom);
            intAck = ($urandom_range(0, 15) == 0);
            isrVec = 20'($urandom);
            rst    = ($urandom_range(0, 63) == 0);
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msp430x_regfile.md
Name: msp430x_regfile

Overview:
Parametrised successor to the CPU register file. Holds R0..R15 at a configurable data width (16-bit MSP430 or 20-bit MSP430X). Adds four things to the core:
- operand-size-aware auto-increment (byte, word, address-word);
- constant-generator decoding on the source port;
- dedicated PC and SP sequencing;
- a hardware interrupt-entry state machine that pushes PC and SR and loads the vector.

It sits between the decoder/sequencer and the ALU/memory interface.

Parameters:
DW, 20, register data width; legal values 16 or 20.
RESET_PC, 'h04400, PC value loaded by reset.
RESET_SP, 'h02400, SP value loaded by reset.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
srcA  in  4  source register address
dstA  in  4  destination register address
srcAs  in  2  source addressing mode; drives constant-generator decode
size  in  2  operand size: 00 word, 01 byte, 10 address-word (DW bits), 11 reserved (treated as word)
RW  in  1  write result to dstA
result  in  DW  write data
srcInc  in  1  post-increment srcA
dstInc  in  1  post-increment dstA
pcInc  in  1  PC <= PC+2 (instruction/extension fetch)
pcLoad  in  1  PC <= pcNew (jump)
pcNew  in  DW  jump target
srWE  in  1  flag update from ALU
SRnew  in  4  {V,N,Z,C}
intAck  in  1  start interrupt entry (single-cycle pulse)
isrVec  in  DW  ISR address
Rsrc  out  DW  source operand, constant-generator resolved
Rdst  out  DW  raw destination register value
PCout  out  DW  current PC
SPout  out  DW  current SP
SRcurrent  out  9  SR[8:0]
GIE  out  1  SR[3]
busy  out  1  interrupt entry in progress
pushData  out  DW  data the memory unit writes at SPout during a push cycle

Behaviour:
- Reset (rst=1 at edge):
  - PC=RESET_PC, SP=RESET_SP, all other registers 0, state IDLE.
  - Outputs after reset: busy=0, GIE=0, SRcurrent=0, Rsrc/Rdst follow the addressed registers.
- Reads are combinational (0-cycle latency).
- Rsrc constant generator:
  - srcA=R3: As 00→0, 01→1, 10→2, 11→all ones.
  - srcA=R2: As 01→0 (absolute), 10→4, 11→8, 00→SR.
  - Otherwise Rsrc = register.
  - Rdst is never substituted.
- Write width on RW:
  - byte: {0, result[7:0]};
  - word: {0, result[15:0]};
  - address-word: result[DW-1:0].
  - When DW=16, word and address-word are identical.
- Register write masks:
  - R3 writes are discarded.
  - PC and SP bit0 are forced to 0.
  - SR keeps bits [8:0]; upper bits read 0.
- Increment amount:
  - byte +1, word +2, address-word +4 (DW=20 only; +2 when DW=16).
  - PC and SP never increment by 1; byte on PC/SP gives +2.
  - Increments on R3 are discarded.
  - Increments on R2 are applied as a normal register (no special casing).
  - srcInc and dstInc on the same register: incremented once.
- Wrap-around: modulo 2^DW.
- Per-register priority, highest first: rst > interrupt FSM > RW > srcInc/dstInc.
- PC priority: pcLoad > RW to PC > PC increment from pcInc or srcInc/dstInc on PC, with at most one +2 applied per cycle.
- SR priority: RW to SR > srWE. srWE writes V→bit8, N→bit2, Z→bit1, C→bit0 and leaves other bits unchanged.
- Interrupt FSM states: IDLE → PUSH_PC → PUSH_SR → VECTOR → IDLE.
  - IDLE: intAck=1 moves to PUSH_PC.
  - PUSH_PC: SP -= 2; pushData = PC.
  - PUSH_SR: SP -= 2; pushData = {PC[DW-1:16] in SR[15:12] when DW=20, SR}.
  - VECTOR: PC = isrVec & ~1; SR = SR & 9'h040 (clears GIE and all other bits except SCG0).
- Interrupt entry timing:
  - busy=1 in PUSH_PC, PUSH_SR and VECTOR.
  - While busy, intAck and all other write/increment inputs are ignored.
  - pushData is 0 in IDLE and VECTOR.
- Reset mid-entry aborts to IDLE with reset values; no partial push is retained.

Test Plan:
1. rst held 3 cycles → PC=0x04400, SP=0x02400, R4=0, busy=0, GIE=0. After that: srcA=R3 with As=00/01/10/11 → Rsrc=0/1/2/0xFFFFF. srcA=R2 with As=10/11 → Rsrc=4/8.
2. RW on R5 with result=0x789AB: size byte→R5=0x000AB; word→0x089AB; address-word→0x789AB. RW on R3 → R3 still reads via CG. RW on SR with result=0x1FF → SRcurrent=0x1FF, GIE=1.
3. R4=0x0FFFE, srcInc on R4: word→0x10000; byte→0x10001; address-word→0x10005. R4=0xFFFFC with address-word inc → 0x00000 (wrap). SP with byte inc → +2. srcInc and dstInc on R6 together → +2 once.
4. Same cycle pcLoad=1 (pcNew=0x05000), RW to PC and pcInc → PC=0x05000. Same cycle RW to SR (result 0x000) and srWE (SRnew=4'b1111) → SR=0.
5. PC=0x04410, SP=0x02400, SR=0x048, isrVec=0x04457, pulse intAck → next 3 cycles busy=1:
   - PUSH_PC: pushData=0x04410, SP→0x023FE;
   - PUSH_SR: pushData=0x048, SP→0x023FC;
   - VECTOR: PC→0x04456, SR→0x040, GIE=0, busy falls.
   A second intAck and RW asserted during busy are ignored.
6. Assert rst in PUSH_SR → next edge: state IDLE, busy=0, SP=0x02400, PC=0x04400.
